// File: rtl/memory_round_engine.sv
// memory_round_engine: one Memory Matrix round (show, hide, guess until win or mistake limit).
// Optional guess-phase time limit enabled by defining ROUND_TIMEOUT_EN.
module memory_round_engine #(
    parameter int SHOW_CYCLES    = 50000000,
    parameter int MAX_MISTAKES   = 3,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] board,
    input  logic       start,
    input  logic       guess_valid,
    input  logic [2:0] guess_idx,
    output logic [7:0] display,
    output logic [7:0] found,
    output logic [2:0] mistakes,
    output logic       busy,
    output logic       won,
    output logic       lost,
    output logic       timed_out
);
    typedef enum logic [2:0] {IDLE, SHOW, INPUT, WIN, LOSE} state_t;

    localparam logic [25:0] SHOW_LOAD = 26'(SHOW_CYCLES - 1);
    localparam logic [2:0]  MAX_M     = 3'(MAX_MISTAKES);

    if (SHOW_CYCLES < 1 || SHOW_CYCLES > 2**26 - 1 || MAX_MISTAKES < 1 || MAX_MISTAKES > 7 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2**30 - 1) begin : g_bad_param
        $error("memory_round_engine: parameter out of legal range");
    end

    state_t      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  found_q, found_d;
    logic [2:0]  mistakes_q, mistakes_d;
    logic [25:0] cnt_q, cnt_d;
    logic [7:0]  display_q, display_d;
    logic        busy_q, busy_d;
    logic        won_q, won_d;
    logic        lost_q, lost_d;
    logic        hit;
`ifdef ROUND_TIMEOUT_EN
    localparam logic [29:0] TO_LOAD = 30'(TIMEOUT_CYCLES - 1);
    logic [29:0] timer_q, timer_d;
    logic        timed_out_q, timed_out_d;
`endif

    assign hit = target_q[guess_idx];

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        found_d    = found_q;
        mistakes_d = mistakes_q;
        cnt_d      = cnt_q;
`ifdef ROUND_TIMEOUT_EN
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
`endif
        unique case (state_q)
            IDLE, WIN, LOSE: begin
                if (start && board != 8'd0) begin
                    state_d    = SHOW;
                    target_d   = board;
                    found_d    = 8'd0;
                    mistakes_d = 3'd0;
                    cnt_d      = SHOW_LOAD;
`ifdef ROUND_TIMEOUT_EN
                    timed_out_d = 1'b0;
`endif
                end
            end
            SHOW: begin
                if (cnt_q == 26'd0) begin
                    state_d = INPUT;
`ifdef ROUND_TIMEOUT_EN
                    timer_d = TO_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - 26'd1;
                end
            end
            INPUT: begin
                if (guess_valid) begin
                    if (hit) found_d = found_q | (8'd1 << guess_idx);
                    else if (mistakes_q != MAX_M) mistakes_d = mistakes_q + 3'd1;
                end
`ifdef ROUND_TIMEOUT_EN
                timer_d = timer_q - 30'd1;
`endif
                // Win beats a same-cycle final mistake, which beats timer expiry.
                if (guess_valid && hit && found_d == target_q) begin
                    state_d = WIN;
                end else if (guess_valid && !hit && mistakes_d == MAX_M) begin
                    state_d = LOSE;
`ifdef ROUND_TIMEOUT_EN
                end else if (timer_q == 30'd0) begin
                    state_d     = LOSE;
                    timed_out_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        display_d = (state_d == INPUT) ? found_d : (state_d == IDLE) ? 8'd0 : target_d;
        busy_d    = (state_d == SHOW) || (state_d == INPUT);
        won_d     = (state_d == WIN);
        lost_d    = (state_d == LOSE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            target_q   <= 8'd0;
            found_q    <= 8'd0;
            mistakes_q <= 3'd0;
            cnt_q      <= 26'd0;
            display_q  <= 8'd0;
            busy_q     <= 1'b0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            found_q    <= found_d;
            mistakes_q <= mistakes_d;
            cnt_q      <= cnt_d;
            display_q  <= display_d;
            busy_q     <= busy_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
        end
    end

`ifdef ROUND_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q     <= 30'd0;
            timed_out_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

    assign display  = display_q;
    assign found    = found_q;
    assign mistakes = mistakes_q;
    assign busy     = busy_q;
    assign won      = won_q;
    assign lost     = lost_q;
endmodule

// File: tb/tb_memory_round_engine.sv
// tb_memory_round_engine: vector table, corner sequences and random run against a behavioural round model.
module tb_memory_round_engine;
    localparam int SC = 4;
    localparam int MM = 3;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] board = 8'd0;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [2:0] guess_idx = 3'd0;
    logic [7:0] display, found;
    logic [2:0] mistakes;
    logic       busy, won, lost, timed_out;

    memory_round_engine #(.SHOW_CYCLES(SC), .MAX_MISTAKES(MM), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .board(board), .start(start),
        .guess_valid(guess_valid), .guess_idx(guess_idx),
        .display(display), .found(found), .mistakes(mistakes),
        .busy(busy), .won(won), .lost(lost), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;

    // Reference model: phase 0 idle, 1 show, 2 guessing, 3 won, 4 lost.
    int         ph = 0;
    logic [7:0] mt = 8'd0;
    logic [7:0] mf = 8'd0;
    int         mm = 0;
    int         sl = 0;
    int         tl = 0;
    bit         mto = 1'b0;

    typedef struct {
        logic       r;
        logic [7:0] b;
        logic       s;
        logic       gv;
        logic [2:0] gi;
        logic [7:0] disp;
        logic [7:0] fnd;
        logic [2:0] mis;
        logic       bsy;
        logic       w;
        logic       l;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [7:0] b, logic s, logic gv, logic [2:0] gi,
                               logic [7:0] disp, logic [7:0] fnd, logic [2:0] mis,
                               logic bsy, logic w, logic l);
        vec_t x;
        x.r = r; x.b = b; x.s = s; x.gv = gv; x.gi = gi;
        x.disp = disp; x.fnd = fnd; x.mis = mis; x.bsy = bsy; x.w = w; x.l = l;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_edge();
        bit miss;
        miss = 1'b0;
        if (!reset) begin
            ph = 0; mt = 8'd0; mf = 8'd0; mm = 0; mto = 1'b0;
        end else if (ph == 0 || ph == 3 || ph == 4) begin
            if (start && board != 8'd0) begin
                ph = 1; mt = board; mf = 8'd0; mm = 0; mto = 1'b0; sl = SC;
            end
        end else if (ph == 1) begin
            sl--;
            if (sl == 0) begin
                ph = 2; tl = TO;
            end
        end else begin
            if (guess_valid) begin
                if (mt[guess_idx]) mf[guess_idx] = 1'b1;
                else begin
                    miss = 1'b1; mm++;
                end
            end
            tl--;
            if (mf == mt) ph = 3;
            else if (miss && mm == MM) ph = 4;
`ifdef ROUND_TIMEOUT_EN
            else if (tl == 0) begin
                ph = 4; mto = 1'b1;
            end
`endif
        end
    endtask

    task automatic step(input logic r, input logic [7:0] b, input logic s, input logic gv, input logic [2:0] gi);
        reset = r; board = b; start = s; guess_valid = gv; guess_idx = gi;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int cyc);
        logic [7:0] ed;
        ed = (ph == 2) ? mf : (ph == 0) ? 8'd0 : mt;
        chk($sformatf("rnd%0d.display", cyc), display, ed);
        chk($sformatf("rnd%0d.found", cyc), found, mf);
        chk($sformatf("rnd%0d.mistakes", cyc), mistakes, mm);
        chk($sformatf("rnd%0d.busy", cyc), busy, (ph == 1 || ph == 2));
        chk($sformatf("rnd%0d.won", cyc), won, ph == 3);
        chk($sformatf("rnd%0d.lost", cyc), lost, ph == 4);
        chk($sformatf("rnd%0d.timed_out", cyc), timed_out, mto);
    endtask

    task automatic enter_input(input logic [7:0] b);
        step(1'b1, b, 1'b1, 1'b0, 3'd0);
        repeat (SC) step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h81, 1, 0, 0, 8'h81, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h81, 0, 0, 0, 8'h81, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h81, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h81, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h01, 8'h01, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 7, 8'h81, 8'h81, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h81, 1, 0, 0, 8'h81, 8'h00, 0, 1, 0, 0));
        repeat (3) tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h81, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 2, 8'h00, 8'h00, 2, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 3, 8'h81, 8'h00, 3, 0, 0, 1));
        tbl.push_back(v(1, 8'h00, 0, 1, 4, 8'h81, 8'h00, 3, 0, 0, 1));
        tbl.push_back(v(1, 8'h01, 1, 0, 0, 8'h01, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h01, 8'h00, 0, 1, 0, 0));
        repeat (2) tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h01, 8'h01, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h01, 8'h01, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h00, 1, 0, 0, 8'h01, 8'h01, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h3C, 1, 0, 0, 8'h3C, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'hA5, 1, 0, 0, 8'hA5, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'hA5, 0, 0, 0, 8'hA5, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(0, 8'hA5, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        repeat (4) tbl.push_back(v(1, 8'h01, 1, 0, 0, 8'h01, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h01, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h01, 1, 1, 0, 8'h01, 8'h01, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h01, 1, 0, 0, 8'h01, 8'h00, 0, 1, 0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].b, tbl[i].s, tbl[i].gv, tbl[i].gi);
            chk($sformatf("vec%0d.display", i), display, tbl[i].disp);
            chk($sformatf("vec%0d.found", i), found, tbl[i].fnd);
            chk($sformatf("vec%0d.mistakes", i), mistakes, tbl[i].mis);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d.won", i), won, tbl[i].w);
            chk($sformatf("vec%0d.lost", i), lost, tbl[i].l);
            chk($sformatf("vec%0d.timed_out", i), timed_out, 1'b0);
        end

        step(1'b0, 8'd0, 1'b0, 1'b0, 3'd0);
`ifdef ROUND_TIMEOUT_EN
        enter_input(8'h03);
        repeat (TO - 1) step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0);
        chk("to_idle.busy_before", busy, 1'b1);
        chk("to_idle.lost_before", lost, 1'b0);
        step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0);
        chk("to_idle.lost", lost, 1'b1);
        chk("to_idle.timed_out", timed_out, 1'b1);
        enter_input(8'h01);
        chk("to_win.timed_out_cleared", timed_out, 1'b0);
        repeat (TO - 1) step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 8'd0, 1'b0, 1'b1, 3'd0);
        chk("to_win.won", won, 1'b1);
        chk("to_win.timed_out", timed_out, 1'b0);
        enter_input(8'h01);
        step(1'b1, 8'd0, 1'b0, 1'b1, 3'd1);
        step(1'b1, 8'd0, 1'b0, 1'b1, 3'd2);
        repeat (TO - 3) step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0);
        chk("to_miss.busy_before", busy, 1'b1);
        step(1'b1, 8'd0, 1'b0, 1'b1, 3'd3);
        chk("to_miss.lost", lost, 1'b1);
        chk("to_miss.timed_out", timed_out, 1'b0);
        chk("to_miss.mistakes", mistakes, 3'd3);
`else
        enter_input(8'h03);
        repeat (100) step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0);
        chk("wait.busy", busy, 1'b1);
        chk("wait.lost", lost, 1'b0);
        chk("wait.timed_out", timed_out, 1'b0);
`endif

        step(1'b0, 8'd0, 1'b0, 1'b0, 3'd0);
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : (8'($urandom) & 8'($urandom));
            step($urandom_range(0, 199) != 0, b, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, 3'($urandom));
            check_model(c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
